seqgen_stream: RTL
==================

# seqgen_stream

Parametrised arithmetic-sequence generator for the video fetch path. A descriptor (start, stride, count, direction) is loaded through a valid/ready handshake. The block then streams the sequence Start, Start±Stride, … as LANES elements per beat over a valid/ready output with backpressure, last-beat flag and per-lane mask. It sits between line/tile control and the pixel/address fetch stages, replacing fixed-length, fixed-stride, dual-clock sequence generation.

## Interface
- WWIDTH, 8, element width; all arithmetic modulo 2^WWIDTH
- SWIDTH, 4, stride width (unsigned)
- CWIDTH, 8, element-count width; max sequence length 2^CWIDTH-1
- LANES, 1, elements per output beat (1, 2, 4 or 8)

- Clk  in  1  single clock, all logic on rising edge
- Rst  in  1  reset, asynchronous, active-high
- LoadValid  in  1  descriptor valid
- LoadReady  out  1  block can accept a descriptor
- LoadStart  in  WWIDTH  first element
- LoadStride  in  SWIDTH  step between consecutive elements
- LoadCount  in  CWIDTH  number of elements
- LoadDown  in  1  0 = ascending (+Stride), 1 = descending (-Stride)
- Abort  in  1  cancel current sequence
- OutValid  out  1  beat valid
- OutReady  in  1  sink accepts beat
- OutData  out  LANES*WWIDTH  lane k in bits [k*WWIDTH +: WWIDTH]
- OutMask  out  LANES  lane k carries a real element
- OutLast  out  1  final beat of sequence
- Busy  out  1  sequence in progress

## Operation
- States: IDLE, RUN.
- IDLE: LoadReady=1. A load occurs when LoadValid&&LoadReady.
  - All descriptor fields are captured.
  - LoadCount=0: stay IDLE, no beat emitted.
  - Otherwise go to RUN.
- RUN: LoadReady=0, Busy=1, OutValid=1.
- Beat contents:
  - Beat b, lane k holds Start ± (b*LANES+k)*Stride, truncated to WWIDTH (wraps silently).
  - Remaining = elements not yet sent.
  - OutMask bit k = (k < Remaining).
  - Masked lanes drive zero.
  - OutLast = (Remaining <= LANES).
- Transfer on OutValid&&OutReady: base advances by LANES*Stride (mod 2^WWIDTH) and Remaining -= min(LANES, Remaining). On transfer of the OutLast beat, go to IDLE.
- Backpressure: while OutValid&&!OutReady, OutData, OutMask and OutLast hold stable.
- Abort:
  - In RUN, go to IDLE next cycle and discard remaining elements.
  - If a transfer occurs in the same cycle as Abort, that beat counts as delivered.
  - Ignored in IDLE; a simultaneous load still happens.
- Reset (any time, including mid-sequence): state IDLE, Remaining 0.
  - While Rst is asserted: LoadReady=0, OutValid=0, OutData=0, OutMask=0, OutLast=0, Busy=0.
  - LoadReady=1 in the first cycle after Rst deasserts.

## Timing
- Load in cycle N: OutValid=1 and first beat presented in cycle N+1.
- With OutReady held high: one beat per cycle; ceil(Count/LANES) beats occupy cycles N+1 … N+ceil(Count/LANES).
- After the last transfer in cycle M: IDLE, LoadReady=1 in M+1. Minimum one idle cycle between sequences; no overlap.
- Abort in cycle M: OutValid=0 and LoadReady=1 in M+1.
- All outputs are registered except LoadReady and Busy, which decode state.
- No combinational path from OutReady to OutValid or OutData.

## Structure
- Package seqgen_pkg holds:
  - state encoding constants (ST_IDLE, ST_RUN)
  - direction constants (DIR_UP, DIR_DOWN)
  - lane-offset helper function (k*Stride, width WWIDTH)
- Sub-module seqgen_lane: one per lane via generate.
  - Computes base ± k*Stride and applies the mask-to-zero.
  - Purely combinational.
  - The registered beat is formed in the parent.
- Parent holds the FSM, base/stride/remaining registers and the handshakes.

## Test plan
- LANES=1, load Start=0x10, Stride=3, Count=4, up, OutReady=1 -> beats 0x10, 0x13, 0x16, 0x19; OutLast on the 4th; LoadReady=1 the next cycle.
- LANES=4, Start=0xFE, Stride=1, Count=6, down -> beat0 {0xFE,0xFD,0xFC,0xFB} mask 1111; beat1 {0xFA,0xF9,0,0} mask 0011, OutLast=1.
- LANES=1, Start=0xFC, Stride=2, Count=4, up -> 0xFC, 0xFE, 0x00, 0x02 (wrap-around).
- Toggle OutReady randomly during a 10-element sequence -> data held stable while stalled; each element delivered exactly once, in order; OutLast only on the final beat.
- Count=0 load -> no OutValid, LoadReady stays 1. Abort after 2 of 8 beats (including a cycle where Abort coincides with a transfer) -> that beat counted, OutValid=0 next cycle, a new load is accepted.
- Assert Rst mid-sequence for 1 cycle -> all outputs zero immediately; after deassert the block is IDLE with LoadReady=1; no stale beats.

Source files
------------

// File: rtl/seqgen_pkg.sv
// Shared constants and helpers for the arithmetic-sequence stream generator.
package seqgen_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Offset of lane k from the beat base; callers truncate to the element width.
    function automatic logic [31:0] laneOffset(input int unsigned k, input logic [31:0] stride);
        return k * stride;
    endfunction

endpackage

// File: rtl/seqgen_lane.sv
// One output lane: base +/- K*stride, forced to zero when the lane is masked off.
module seqgen_lane
    import seqgen_pkg::*;
#(
    parameter int          WWIDTH = 8,
    parameter int          SWIDTH = 4,
    parameter int unsigned K      = 0
) (
    input  logic [WWIDTH-1:0] Base,
    input  logic [SWIDTH-1:0] Stride,
    input  logic              Down,
    input  logic              Mask,
    output logic [WWIDTH-1:0] Data
);

    logic [WWIDTH-1:0] offset;

    assign offset = WWIDTH'(laneOffset(K, 32'(Stride)));

    always_comb begin
        Data = '0;
        if (Mask) begin
            Data = (Down == DIR_DOWN) ? Base - offset : Base + offset;
        end
    end

endmodule

// File: rtl/seqgen_stream.sv
// Streams Start, Start+/-Stride, ... as LANES elements per beat; the beat is
// computed from next-state values so that every output leaves a register.
module seqgen_stream
    import seqgen_pkg::*;
#(
    parameter int WWIDTH = 8,
    parameter int SWIDTH = 4,
    parameter int CWIDTH = 8,
    parameter int LANES  = 1
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    LoadValid,
    output logic                    LoadReady,
    input  logic [WWIDTH-1:0]       LoadStart,
    input  logic [SWIDTH-1:0]       LoadStride,
    input  logic [CWIDTH-1:0]       LoadCount,
    input  logic                    LoadDown,
    input  logic                    Abort,
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic [LANES*WWIDTH-1:0] OutData,
    output logic [LANES-1:0]        OutMask,
    output logic                    OutLast,
    output logic                    Busy
);

    logic [0:0]              stateReg, stateNext;
    logic [WWIDTH-1:0]       baseReg, baseNext;
    logic [SWIDTH-1:0]       strideReg, strideNext;
    logic                    downReg, downNext;
    logic [CWIDTH-1:0]       remainingReg, remainingNext;
    logic                    validNext;
    logic                    lastNext;
    logic [LANES-1:0]        maskNext;
    logic [LANES*WWIDTH-1:0] dataNext;
    logic [WWIDTH-1:0]       beatStep;
    logic                    loadFire;
    logic                    xfer;

    assign LoadReady = (stateReg == ST_IDLE) && !Rst;
    assign Busy      = (stateReg == ST_RUN);
    assign loadFire  = LoadValid && LoadReady;
    assign xfer      = OutValid && OutReady;
    assign beatStep  = WWIDTH'(laneOffset(LANES, 32'(strideReg)));

    always_comb begin
        stateNext     = stateReg;
        baseNext      = baseReg;
        strideNext    = strideReg;
        downNext      = downReg;
        remainingNext = remainingReg;
        if (stateReg == ST_IDLE) begin
            if (loadFire) begin
                baseNext      = LoadStart;
                strideNext    = LoadStride;
                downNext      = LoadDown;
                remainingNext = LoadCount;
                if (LoadCount != '0) begin
                    stateNext = ST_RUN;
                end
            end
        end else if (Abort || (xfer && OutLast)) begin
            // A beat transferred alongside Abort is already delivered; only the rest is dropped.
            stateNext     = ST_IDLE;
            remainingNext = '0;
        end else if (xfer) begin
            baseNext      = (downReg == DIR_DOWN) ? baseReg - beatStep : baseReg + beatStep;
            remainingNext = remainingReg - CWIDTH'(LANES);
        end
    end

    assign validNext = (stateNext == ST_RUN);
    assign lastNext  = validNext && (32'(remainingNext) <= 32'(LANES));

    for (genvar gi = 0; gi < LANES; gi++) begin : gLane
        assign maskNext[gi] = validNext && (32'(remainingNext) > 32'(gi));

        seqgen_lane #(
            .WWIDTH (WWIDTH),
            .SWIDTH (SWIDTH),
            .K      (gi)
        ) uLane (
            .Base   (baseNext),
            .Stride (strideNext),
            .Down   (downNext),
            .Mask   (maskNext[gi]),
            .Data   (dataNext[gi*WWIDTH +: WWIDTH])
        );
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            stateReg     <= ST_IDLE;
            baseReg      <= '0;
            strideReg    <= '0;
            downReg      <= DIR_UP;
            remainingReg <= '0;
            OutValid     <= 1'b0;
            OutData      <= '0;
            OutMask      <= '0;
            OutLast      <= 1'b0;
        end else begin
            stateReg     <= stateNext;
            baseReg      <= baseNext;
            strideReg    <= strideNext;
            downReg      <= downNext;
            remainingReg <= remainingNext;
            OutValid     <= validNext;
            OutData      <= dataNext;
            OutMask      <= maskNext;
            OutLast      <= lastNext;
        end
    end

endmodule
